// File: rtl/logic_op_pipe_if.sv
// logic_op_pipe_if: operand/result handshake bundle for logic_op_pipe.
// Upstream side: in_valid, in_ready, op, a, b.
// Downstream side: out_valid, out_ready, y, y_op (plus y_par when
// LOGIC_OP_PARITY_EN is defined).
// master = the block driving operands and sinking results (bench/system).
// slave  = logic_op_pipe itself.
interface logic_op_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [2:0]       y_op;
`ifdef LOGIC_OP_PARITY_EN
    logic             y_par;
`endif

    modport master (
        output in_valid, op, a, b, out_ready,
`ifdef LOGIC_OP_PARITY_EN
        input  y_par,
`endif
        input  in_ready, out_valid, y, y_op
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
`ifdef LOGIC_OP_PARITY_EN
        output y_par,
`endif
        output in_ready, out_valid, y, y_op
    );
endinterface

// File: rtl/logic_op_pipe.sv
// logic_op_pipe: 2-stage valid/ready pipeline applying one of eight
// bitwise ops to two WIDTH-bit operands, with a built-in sweep engine
// that replays every op against every replicated 1-bit (a,b) pair.
// Ports: clk, rst (sync, active-high); bus (logic_op_pipe_if.slave:
// in_valid/in_ready/op/a/b upstream, out_valid/out_ready/y/y_op
// downstream); sweep_start in, sweep_busy/sweep_done out.
// Option: define LOGIC_OP_PARITY_EN to add bus.y_par = ^y.
module logic_op_pipe #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    logic_op_pipe_if.slave bus,
    input  logic           sweep_start,
    output logic           sweep_busy,
    output logic           sweep_done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [4:0]       cnt_q;

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             out_valid_q;
    logic [WIDTH-1:0] y_q;
    logic [2:0]       y_op_q;
`ifdef LOGIC_OP_PARITY_EN
    logic             y_par_q;
`endif

    logic             adv1;
    logic             adv2;
    logic             src_valid;
    logic [2:0]       src_op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] res;

    assign adv2 = !out_valid_q || bus.out_ready;
    assign adv1 = !s1_valid || adv2;

    // The start cycle is also blocked so the sweep never interleaves
    // with an operand accepted on the same edge it begins.
    assign bus.in_ready = adv1 && (state_q == IDLE) && !sweep_start;

    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.y_op      = y_op_q;
`ifdef LOGIC_OP_PARITY_EN
    assign bus.y_par     = y_par_q;
`endif

    assign sweep_busy = (state_q != IDLE);
    assign sweep_done = (state_q == DONE);

    // Stage-1 source: sweep counter while running, else external port.
    always_comb begin
        src_valid = bus.in_valid && bus.in_ready;
        src_op    = bus.op;
        src_a     = bus.a;
        src_b     = bus.b;
        if (state_q == RUN) begin
            src_valid = 1'b1;
            src_op    = cnt_q[4:2];
            src_a     = {WIDTH{cnt_q[1]}};
            src_b     = {WIDTH{cnt_q[0]}};
        end
    end

    always_comb begin
        res = '0;
        unique case (s1_op)
            3'd0: res = s1_a & s1_b;
            3'd1: res = s1_a | s1_b;
            3'd2: res = ~(s1_a & s1_b);
            3'd3: res = s1_a ^ s1_b;
            3'd4: res = ~(s1_a | s1_b);
            3'd5: res = ~(s1_a ^ s1_b);
            3'd6: res = ~s1_a;
            3'd7: res = s1_a;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sweep_start) state_d = RUN;
            end
            RUN: begin
                if (adv1 && cnt_q == 5'd31) state_d = DRAIN;
            end
            DRAIN: begin
                if (!s1_valid && !out_valid_q) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RUN && adv1) cnt_q <= cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (adv1) begin
            s1_valid <= src_valid;
            if (src_valid) begin
                s1_op <= src_op;
                s1_a  <= src_a;
                s1_b  <= src_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            y_op_q      <= '0;
`ifdef LOGIC_OP_PARITY_EN
            y_par_q     <= 1'b0;
`endif
        end else if (adv2) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                y_q    <= res;
                y_op_q <= s1_op;
`ifdef LOGIC_OP_PARITY_EN
                y_par_q <= ^res;
`endif
            end
        end
    end

endmodule
